// File: rtl/debug_dump_tx.sv
// debug_dump_tx
// Host-side end of the datapath debug interface. Host command bytes gate
// the processor clock-enable: run until halt, single-step, or dump only.
// Every dump takes one snapshot of the datapath debug outputs together with
// the executed-cycle count. The snapshot goes out as a fixed 189-byte frame
// over a valid/ready byte handshake toward the UART transmitter.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-low reset
//   cmd_valid  one-cycle strobe, cmd_byte valid (UART RX)
//   cmd_byte   received command byte
//   du_reg     register file snapshot (1024 b)
//   du_mem     data memory snapshot (256 b)
//   du_if_id   IF/ID latch snapshot (64 b)
//   du_id_ex   ID/EX latch snapshot (126 b)
//   du_halt    halt instruction has reached WB
//   cpu_en     processor clock enable
//   tx_valid   tx_data valid
//   tx_data    frame byte to UART TX
//   tx_ready   UART TX accepts a byte this cycle
//   busy       high whenever not idle
module debug_dump_tx #(
  parameter logic [7:0] HEADER   = 8'hA5,
  parameter logic [7:0] CMD_RUN  = 8'h63,
  parameter logic [7:0] CMD_STEP = 8'h73,
  parameter logic [7:0] CMD_DUMP = 8'h64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  input  logic [7:0]    cmd_byte,
  input  logic [1023:0] du_reg,
  input  logic [255:0]  du_mem,
  input  logic [63:0]   du_if_id,
  input  logic [125:0]  du_id_ex,
  input  logic          du_halt,
  output logic          cpu_en,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  input  logic          tx_ready,
  output logic          busy
);

  localparam int FRAME_BYTES = 189;
  localparam int FRAME_W     = FRAME_BYTES * 8;
  localparam logic [7:0] LAST_IDX = 8'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_SNAP,
    S_SEND
  } state_t;

  state_t               state_q;
  logic [FRAME_W-1:0]   frame_q;
  logic [7:0]           idx_q;
  logic [31:0]          cyc_cnt_q;
  logic [31:0]          cyc_cnt_d;
  logic                 tx_valid_q;

  // In RUN the enable drops in the same cycle halt becomes visible, so no
  // extra instruction slips through after the halt reaches WB.
  assign cpu_en    = (state_q == S_STEP) | ((state_q == S_RUN) & ~du_halt);
  assign busy      = (state_q != S_IDLE);
  assign tx_valid  = tx_valid_q;
  // The outgoing byte is always the top byte of the frame shift register,
  // so it is registered and holds for as long as the handshake stalls.
  assign tx_data   = frame_q[FRAME_W-1 -: 8];
  assign cyc_cnt_d = cyc_cnt_q + 32'(cpu_en);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      idx_q      <= '0;
      cyc_cnt_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      unique case (state_q)
        S_IDLE: begin
          // Commands are only decoded here; anything arriving while busy
          // is dropped, since there is no command queue.
          if (cmd_valid) begin
            if (cmd_byte == CMD_RUN && !du_halt) begin
              state_q <= S_RUN;
            end else if (cmd_byte == CMD_STEP && !du_halt) begin
              state_q <= S_STEP;
            end else if (cmd_byte == CMD_DUMP) begin
              state_q <= S_SNAP;
            end
          end
        end
        S_RUN: begin
          if (du_halt) begin
            state_q <= S_SNAP;
          end
        end
        S_STEP: begin
          state_q <= S_SNAP;
        end
        S_SNAP: begin
          // The whole frame, header and count included, is captured at once
          // so later snapshot changes cannot leak into it.
          frame_q    <= {HEADER, cyc_cnt_q, du_if_id, 2'b00, du_id_ex,
                         du_reg, du_mem};
          idx_q      <= '0;
          tx_valid_q <= 1'b1;
          state_q    <= S_SEND;
        end
        S_SEND: begin
          if (tx_valid_q && tx_ready) begin
            if (idx_q == LAST_IDX) begin
              tx_valid_q <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              idx_q   <= idx_q + 8'd1;
              frame_q <= {frame_q[FRAME_W-9:0], 8'h00};
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_dump_tx.sv
module tb_debug_dump_tx;

  localparam logic [7:0] CMD_RUN  = 8'h63;
  localparam logic [7:0] CMD_STEP = 8'h73;
  localparam logic [7:0] CMD_DUMP = 8'h64;
  localparam int NBYTES = 189;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic [7:0]    cmd_byte;
  logic [1023:0] du_reg;
  logic [255:0]  du_mem;
  logic [63:0]   du_if_id;
  logic [125:0]  du_id_ex;
  logic          du_halt;
  logic          cpu_en;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  int en_cnt   = 0;
  logic [31:0] m_cnt;
  logic [7:0]  exp_q [NBYTES];
  logic [7:0]  got_q [NBYTES];

  debug_dump_tx dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_byte (cmd_byte),
    .du_reg   (du_reg),
    .du_mem   (du_mem),
    .du_if_id (du_if_id),
    .du_id_ex (du_id_ex),
    .du_halt  (du_halt),
    .cpu_en   (cpu_en),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Count processor-enable cycles, sampled mid low phase.
  always @(negedge clk) begin
    #2;
    if (cpu_en === 1'b1) en_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic rand_snap();
    logic [127:0] t;
    for (int i = 0; i < 32; i++) du_reg[32*i +: 32] = $urandom;
    for (int i = 0; i < 8; i++)  du_mem[32*i +: 32] = $urandom;
    du_if_id = {$urandom, $urandom};
    t = {$urandom, $urandom, $urandom, $urandom};
    du_id_ex = t[125:0];
  endtask

  // Expected frame straight from the byte layout: header, count, then each
  // snapshot field most-significant byte first.
  task automatic build_frame();
    int k;
    logic [127:0] idx_pad;
    k = 0;
    exp_q[k] = 8'hA5; k++;
    for (int i = 3; i >= 0; i--)   begin exp_q[k] = m_cnt[8*i +: 8];    k++; end
    for (int i = 7; i >= 0; i--)   begin exp_q[k] = du_if_id[8*i +: 8]; k++; end
    idx_pad = {2'b00, du_id_ex};
    for (int i = 15; i >= 0; i--)  begin exp_q[k] = idx_pad[8*i +: 8];  k++; end
    for (int i = 127; i >= 0; i--) begin exp_q[k] = du_reg[8*i +: 8];   k++; end
    for (int i = 31; i >= 0; i--)  begin exp_q[k] = du_mem[8*i +: 8];   k++; end
  endtask

  // All tasks below start and end right after a falling edge.
  task automatic send_cmd(input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd_byte  = b;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_byte  = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    m_cnt = 32'h0;
  endtask

  task automatic collect_frame(input string tag, input int ready_pct, input bit perturb,
                               input bit inj, input int inj_at);
    int got, waitc;
    bit stall, injected;
    logic [7:0] prev;
    got = 0; waitc = 0; stall = 0; injected = 0; prev = 8'h00;
    while (!tx_valid && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check({tag, "_start"}, 32'(tx_valid), 32'd1);
    if (!tx_valid) return;
    waitc = 0;
    while (got < NBYTES && waitc < 5000) begin
      if (stall) begin
        check({tag, "_hold_valid"}, 32'(tx_valid), 32'd1);
        check({tag, "_hold_data"}, 32'(tx_data), 32'(prev));
      end
      if (inj && !injected && got == inj_at) begin
        cmd_valid = 1'b1; cmd_byte = CMD_STEP; injected = 1;
      end else begin
        cmd_valid = 1'b0; cmd_byte = 8'h00;
      end
      if (perturb && $urandom_range(0, 3) == 0) rand_snap();
      tx_ready = ($urandom_range(0, 99) < ready_pct);
      if (tx_valid && tx_ready) begin
        got_q[got] = tx_data;
        check($sformatf("%s_byte%0d", tag, got), 32'(tx_data), 32'(exp_q[got]));
        got++;
      end
      stall = tx_valid && !tx_ready;
      prev  = tx_data;
      @(negedge clk);
      waitc++;
    end
    cmd_valid = 1'b0;
    tx_ready  = 1'b1;
    check({tag, "_len"}, 32'(got), 32'(NBYTES));
    check({tag, "_end_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_end_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int e0;
    reset = 1'b0; cmd_valid = 1'b0; cmd_byte = 8'h00; du_halt = 1'b0;
    tx_ready = 1'b1; m_cnt = 32'h0;
    du_reg = '0; du_mem = '0; du_if_id = '0; du_id_ex = '0;
    repeat (3) @(negedge clk);
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Field placement with marker bytes.
    rand_snap();
    du_reg[1023:1016] = 8'h12; du_mem[7:0] = 8'h34;
    du_if_id[63:56] = 8'hAB; du_id_ex[125:120] = 6'h3F;
    build_frame();
    send_cmd(CMD_DUMP);
    collect_frame("dump", 100, 1, 0, 0);
    check("mark_b5", 32'(got_q[5]), 32'hAB);
    check("mark_b13", 32'(got_q[13]), 32'h3F);
    check("mark_b29", 32'(got_q[29]), 32'h12);
    check("mark_b188", 32'(got_q[188]), 32'h34);

    // Two single steps with latency check.
    for (int s = 1; s <= 2; s++) begin
      rand_snap();
      m_cnt = m_cnt + 1;
      build_frame();
      e0 = en_cnt;
      send_cmd(CMD_STEP);
      check("step_en_e1", 32'(cpu_en), 32'd1);
      check("step_vld_e1", 32'(tx_valid), 32'd0);
      @(negedge clk);
      check("step_en_e2", 32'(cpu_en), 32'd0);
      check("step_vld_e2", 32'(tx_valid), 32'd0);
      @(negedge clk);
      check("step_vld_e3", 32'(tx_valid), 32'd1);
      collect_frame($sformatf("step%0d", s), 100, 0, 0, 0);
      check("step_en_cycles", 32'(en_cnt - e0), 32'd1);
      check("step_count", {got_q[1], got_q[2], got_q[3], got_q[4]}, 32'(s));
    end

    // Run until halt after ten enabled cycles.
    do_reset();
    @(negedge clk);
    rand_snap();
    m_cnt = 32'd10;
    build_frame();
    e0 = en_cnt;
    send_cmd(CMD_RUN);
    repeat (10) @(negedge clk);
    du_halt = 1'b1;
    collect_frame("run", 100, 0, 0, 0);
    check("run_en_cycles", 32'(en_cnt - e0), 32'd10);
    check("run_count", {got_q[1], got_q[2], got_q[3], got_q[4]}, 32'h0000000A);
    e0 = en_cnt;
    send_cmd(CMD_RUN);
    check("halt_run_busy", 32'(busy), 32'd0);
    send_cmd(CMD_STEP);
    check("halt_step_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("halt_busy", 32'(busy), 32'd0);
    check("halt_en_cycles", 32'(en_cnt - e0), 32'd0);
    rand_snap();
    build_frame();
    send_cmd(CMD_DUMP);
    collect_frame("halt_dump", 100, 0, 0, 0);
    du_halt = 1'b0;

    // Back-pressure with random ready and snapshot churn during sending.
    for (int f = 0; f < 3; f++) begin
      rand_snap();
      build_frame();
      send_cmd(CMD_DUMP);
      collect_frame($sformatf("bp%0d", f), 30, 1, 0, 0);
    end

    // Reset in the middle of a frame.
    send_cmd(CMD_DUMP);
    repeat (25) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(tx_valid), 32'd0);
    check("midrst_cpu_en", 32'(cpu_en), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_cnt = 32'h0;
    @(negedge clk);
    rand_snap();
    build_frame();
    send_cmd(CMD_DUMP);
    collect_frame("postrst", 100, 0, 0, 0);
    check("postrst_hdr", 32'(got_q[0]), 32'hA5);
    check("postrst_count", {got_q[1], got_q[2], got_q[3], got_q[4]}, 32'h0);

    // Counter wrap, with a step command sent while the frame is going out.
    dut.cyc_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    m_cnt = 32'h0;
    rand_snap();
    build_frame();
    e0 = en_cnt;
    send_cmd(CMD_STEP);
    collect_frame("wrap", 100, 0, 1, 40);
    check("wrap_count", {got_q[1], got_q[2], got_q[3], got_q[4]}, 32'h0);
    repeat (3) @(negedge clk);
    check("wrap_busy", 32'(busy), 32'd0);
    check("wrap_en_cycles", 32'(en_cnt - e0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
